hd63701_phase_seq: RTL and testbench

- Phase sequencer for the ikbd HD63701 core. It drives the 6-bit PHASE and 8-bit OPCODE consumed by the microcode ROM.
- It takes back a decoded 2-bit "next" field from the current microcode word and sequences reset, vector fetch, opcode fetch, execute steps, interrupt entry, WAI and SLP.
- It arbitrates NMI/IRQ, drives vector selection, and owns the opcode latch.

---
 rtl/hd63701_phase_seq.sv | 182 ++++++++++++++++++
 tb/tb_hd63701_phase_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd63701_phase_seq.sv
// Phase/opcode sequencer feeding the HD63701 microcode ROM: reset and vector fetch,
// opcode fetch, execute steps, interrupt entry, WAI and SLP, with NMI/IRQ arbitration.
module hd63701_phase_seq #(
  parameter logic [7:0]  NOP_OPC   = 8'h01,
  parameter int unsigned CLKEN_GAP = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clken,
  input  logic [1:0] mc_next,
  input  logic [7:0] DIN,
  input  logic       NMI,
  input  logic       IRQ,
  input  logic       IMASK,
  output logic [5:0] PHASE,
  output logic [7:0] OPCODE,
  output logic [1:0] vec_sel,
  output logic       fetch,
  output logic       sleeping
);

  typedef enum logic [5:0] {
    PhRst   = 6'd0,
    PhVect  = 6'd1,
    PhVec1  = 6'd2,
    PhVec2  = 6'd3,
    PhLoad  = 6'd4,
    PhExec  = 6'd8,
    PhExec1 = 6'd9,
    PhExec2 = 6'd10,
    PhExec3 = 6'd11,
    PhExec4 = 6'd12,
    PhExec5 = 6'd13,
    PhExec6 = 6'd14,
    PhExec7 = 6'd15,
    PhExec8 = 6'd16,
    PhExec9 = 6'd17,
    PhIntr  = 6'd24,
    PhIntr1 = 6'd25,
    PhIntr2 = 6'd26,
    PhIntr3 = 6'd27,
    PhIntr4 = 6'd28,
    PhIntr5 = 6'd29,
    PhIntr6 = 6'd30,
    PhIntr7 = 6'd31,
    PhIntr8 = 6'd32,
    PhIntr9 = 6'd33,
    PhHalt  = 6'd62,
    PhSleep = 6'd63
  } phase_e;

  localparam logic [1:0] McCont = 2'd0;
  localparam logic [1:0] McEnd  = 2'd1;
  localparam logic [1:0] McWai  = 2'd2;
  localparam logic [1:0] McSlp  = 2'd3;

  localparam logic [1:0] VecRst = 2'd0;
  localparam logic [1:0] VecNmi = 2'd1;
  localparam logic [1:0] VecIrq = 2'd2;

  localparam int unsigned GapW = $clog2(CLKEN_GAP + 1);

  phase_e          r_phase;
  phase_e          w_phase_nxt;
  logic [7:0]      r_opcode;
  logic [1:0]      r_vec_sel;
  logic [1:0]      w_vec_nxt;
  logic            r_wai;
  logic            w_wai_nxt;
  logic            r_nmi_prev;
  logic            r_nmi_pend;
  logic            w_nmi_rise;
  logic            w_nmi_clr;
  logic            w_load;
  logic            w_irq_req;
  logic [GapW-1:0] r_gap;

  assign w_nmi_rise = NMI & ~r_nmi_prev;
  assign w_irq_req  = IRQ & ~IMASK;

  always_comb begin
    w_phase_nxt = r_phase;
    w_vec_nxt   = r_vec_sel;
    w_wai_nxt   = r_wai;
    w_nmi_clr   = 1'b0;
    w_load      = 1'b0;
    case (r_phase)
      PhRst:  w_phase_nxt = PhVect;
      PhVect: w_phase_nxt = PhVec1;
      PhVec1: w_phase_nxt = PhVec2;
      PhVec2: w_phase_nxt = PhLoad;
      PhLoad: begin
        w_load      = 1'b1;
        w_phase_nxt = PhExec;
      end
      PhExec, PhExec1, PhExec2, PhExec3, PhExec4,
      PhExec5, PhExec6, PhExec7, PhExec8, PhExec9: begin
        case (mc_next)
          McCont: begin
            // Running off the end of the execute window means broken microcode.
            w_phase_nxt = (r_phase == PhExec9) ? PhHalt : phase_e'(r_phase + 6'd1);
          end
          McEnd: begin
            if (r_nmi_pend) begin
              w_phase_nxt = PhIntr;
              w_vec_nxt   = VecNmi;
              w_nmi_clr   = 1'b1;
            end else if (w_irq_req) begin
              w_phase_nxt = PhIntr;
              w_vec_nxt   = VecIrq;
            end else begin
              w_phase_nxt = PhLoad;
            end
          end
          McWai: begin
            w_wai_nxt   = 1'b1;
            w_phase_nxt = PhIntr;
          end
          default: w_phase_nxt = PhSleep;
        endcase
      end
      PhIntr, PhIntr1, PhIntr2, PhIntr3, PhIntr4, PhIntr5, PhIntr6: begin
        w_phase_nxt = phase_e'(r_phase + 6'd1);
      end
      PhIntr7: w_phase_nxt = r_wai ? PhSleep : PhVect;
      PhSleep: begin
        // WAI already stacked the state, so its wake-up goes straight to the vector.
        if (r_nmi_pend || w_irq_req) begin
          w_vec_nxt   = r_nmi_pend ? VecNmi : VecIrq;
          w_nmi_clr   = r_nmi_pend;
          w_phase_nxt = r_wai ? PhVect : PhIntr;
          w_wai_nxt   = 1'b0;
        end
      end
      default: w_phase_nxt = PhHalt;
    endcase
  end

  always_ff @(posedge CLK) begin
    r_nmi_prev <= NMI;
    if (RST) begin
      r_phase    <= PhRst;
      r_opcode   <= NOP_OPC;
      r_vec_sel  <= VecRst;
      r_wai      <= 1'b0;
      r_nmi_pend <= 1'b0;
    end else begin
      if (w_nmi_rise) begin
        r_nmi_pend <= 1'b1;
      end else if (clken && w_nmi_clr) begin
        r_nmi_pend <= 1'b0;
      end
      if (clken) begin
        r_phase   <= w_phase_nxt;
        r_vec_sel <= w_vec_nxt;
        r_wai     <= w_wai_nxt;
        if (w_load) begin
          r_opcode <= DIN;
        end
      end
    end
  end

  // The microcode ROM needs CLKEN_GAP clocks between enables to present the next word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gap <= GapW'(CLKEN_GAP);
    end else if (clken) begin
      assert (r_gap >= GapW'(CLKEN_GAP));
      r_gap <= GapW'(1);
    end else if (r_gap < GapW'(CLKEN_GAP)) begin
      r_gap <= r_gap + GapW'(1);
    end
  end

  assign PHASE    = r_phase;
  assign OPCODE   = r_opcode;
  assign vec_sel  = r_vec_sel;
  assign fetch    = (r_phase == PhLoad);
  assign sleeping = (r_phase == PhSleep);

endmodule

// File: tb/tb_hd63701_phase_seq.sv
// Scoreboard bench for hd63701_phase_seq: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the phase rules.
module tb_hd63701_phase_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       clken = 1'b0;
  logic [1:0] mc_next = 2'd0;
  logic [7:0] DIN = 8'h00;
  logic       NMI = 1'b0;
  logic       IRQ = 1'b0;
  logic       IMASK = 1'b0;
  logic [5:0] PHASE;
  logic [7:0] OPCODE;
  logic [1:0] vec_sel;
  logic       fetch;
  logic       sleeping;

  always #5 CLK = ~CLK;

  hd63701_phase_seq #(
    .NOP_OPC  (8'h01),
    .CLKEN_GAP(3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .clken   (clken),
    .mc_next (mc_next),
    .DIN     (DIN),
    .NMI     (NMI),
    .IRQ     (IRQ),
    .IMASK   (IMASK),
    .PHASE   (PHASE),
    .OPCODE  (OPCODE),
    .vec_sel (vec_sel),
    .fetch   (fetch),
    .sleeping(sleeping)
  );

  typedef struct {
    logic [5:0] ph;
    logic [7:0] opc;
    logic [1:0] vs;
    logic       f;
    logic       s;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_cycle = 0;

  // Reference model state
  int   m_phase = 0;
  int   m_opc = 1;
  int   m_vec = 0;
  bit   m_wai = 0;
  bit   m_pend = 0;
  bit   m_nmi_prev = 0;

  task automatic model_step();
    bit nmi_rise, irq_ok, clr;
    nmi_rise   = NMI && !m_nmi_prev;
    m_nmi_prev = NMI;
    irq_ok     = IRQ && !IMASK;
    clr        = 0;
    if (RST) begin
      m_phase = 0; m_opc = 8'h01; m_vec = 0; m_wai = 0; m_pend = 0;
    end else begin
      if (clken) begin
        if (m_phase <= 3) begin
          m_phase = m_phase + 1;
        end else if (m_phase == 4) begin
          m_opc = DIN; m_phase = 8;
        end else if (m_phase >= 8 && m_phase <= 17) begin
          if (mc_next == 0) begin
            m_phase = (m_phase == 17) ? 62 : m_phase + 1;
          end else if (mc_next == 1) begin
            if (m_pend) begin
              m_phase = 24; m_vec = 1; clr = 1;
            end else if (irq_ok) begin
              m_phase = 24; m_vec = 2;
            end else begin
              m_phase = 4;
            end
          end else if (mc_next == 2) begin
            m_wai = 1; m_phase = 24;
          end else begin
            m_phase = 63;
          end
        end else if (m_phase >= 24 && m_phase <= 30) begin
          m_phase = m_phase + 1;
        end else if (m_phase == 31) begin
          m_phase = m_wai ? 63 : 1;
        end else if (m_phase == 63) begin
          if (m_pend || irq_ok) begin
            m_vec   = m_pend ? 1 : 2;
            clr     = m_pend;
            m_phase = m_wai ? 1 : 24;
            m_wai   = 0;
          end
        end else begin
          m_phase = 62;
        end
      end
      if (nmi_rise) m_pend = 1;
      else if (clr) m_pend = 0;
    end
  endtask

  // One CLK cycle: inputs already set, model advanced, expectation queued.
  task automatic tick(input logic ce);
    exp_t e;
    @(negedge CLK);
    #1;
    clken = ce;
    model_step();
    e.ph  = 6'(m_phase);
    e.opc = 8'(m_opc);
    e.vs  = 2'(m_vec);
    e.f   = (m_phase == 4);
    e.s   = (m_phase == 63);
    q.push_back(e);
    @(posedge CLK);
    #1;
    clken = 1'b0;
  endtask

  task automatic step(input logic [1:0] mc);
    mc_next = mc;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic steps(input int n, input logic [1:0] mc);
    for (int i = 0; i < n; i++) step(mc);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(1'b0);
    RST = 1'b0;
  endtask

  task automatic nmi_pulse();
    NMI = 1'b1;
    tick(1'b0);
    NMI = 1'b0;
    tick(1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Monitor: every cycle the DUT presents a new state; compare against the queue head.
  always @(negedge CLK) begin
    n_cycle++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_checks++;
      if (PHASE === mon_e.ph && OPCODE === mon_e.opc && vec_sel === mon_e.vs &&
          fetch === mon_e.f && sleeping === mon_e.s) begin
        n_pass++;
      end else begin
        $display("FAIL scoreboard cyc%0d: got PHASE=%0d OPC=%h vec=%0d fetch=%b sleep=%b, expected PHASE=%0d OPC=%h vec=%0d fetch=%b sleep=%b",
                 n_cycle, PHASE, OPCODE, vec_sel, fetch, sleeping,
                 mon_e.ph, mon_e.opc, mon_e.vs, mon_e.f, mon_e.s);
      end
    end
  end

  initial begin
    int r;
    int n;
    // Reset and vector sequence
    RST = 1'b1;
    tick(1'b0);
    tick(1'b1);
    RST = 1'b0;
    chk("reset_phase", PHASE, 0);
    chk("reset_opcode", OPCODE, 8'h01);
    chk("reset_vec", vec_sel, 0);
    steps(4, 2'd1);
    chk("vect_to_load", PHASE, 4);
    chk("fetch_in_load", fetch, 1);
    chk("vec_after_reset", vec_sel, 0);
    DIN = 8'h86;
    step(2'd0);
    DIN = 8'h00;
    chk("load_phase", PHASE, 8);
    chk("load_opcode", OPCODE, 8'h86);

    // CONT, CONT, END; then overrun into HALT
    steps(2, 2'd0);
    chk("cont_cont", PHASE, 10);
    step(2'd1);
    chk("end_no_irq", PHASE, 4);
    step(2'd0);
    steps(9, 2'd0);
    chk("exec9", PHASE, 17);
    step(2'd0);
    chk("overrun_halt", PHASE, 62);
    IRQ = 1'b1;
    steps(3, 2'd1);
    IRQ = 1'b0;
    chk("halt_holds", PHASE, 62);

    // IRQ entry, then masked IRQ
    do_reset();
    steps(5, 2'd0);
    IRQ = 1'b1;
    IMASK = 1'b0;
    step(2'd1);
    chk("irq_intr", PHASE, 24);
    steps(8, 2'd0);
    chk("irq_vect", PHASE, 1);
    chk("irq_vec_sel", vec_sel, 2);
    steps(4, 2'd0);
    chk("irq_back_exec", PHASE, 8);
    IMASK = 1'b1;
    step(2'd1);
    chk("masked_irq", PHASE, 4);
    IMASK = 1'b0;
    IRQ = 1'b0;
    step(2'd0);

    // NMI pulse between clkens beats IRQ; pending clears after use
    IRQ = 1'b1;
    nmi_pulse();
    step(2'd1);
    chk("nmi_intr", PHASE, 24);
    chk("nmi_vec", vec_sel, 1);
    steps(12, 2'd0);
    chk("nmi_back_exec", PHASE, 8);
    step(2'd1);
    chk("irq_after_nmi_vec", vec_sel, 2);
    IRQ = 1'b0;
    steps(12, 2'd0);

    // WAI from EXEC1, sleep, wake on IRQ
    step(2'd0);
    step(2'd2);
    chk("wai_intr", PHASE, 24);
    steps(8, 2'd0);
    chk("wai_sleep", PHASE, 63);
    chk("wai_sleeping", sleeping, 1);
    steps(20, 2'd0);
    chk("wai_hold", PHASE, 63);
    IRQ = 1'b1;
    step(2'd0);
    IRQ = 1'b0;
    chk("wai_wake_vect", PHASE, 1);
    chk("wai_wake_vec", vec_sel, 2);

    // SLP path, wake on NMI
    steps(4, 2'd0);
    step(2'd3);
    chk("slp_sleep", PHASE, 63);
    steps(3, 2'd0);
    nmi_pulse();
    step(2'd0);
    chk("slp_wake_intr", PHASE, 24);
    chk("slp_wake_vec", vec_sel, 1);
    steps(8, 2'd0);
    chk("slp_vect", PHASE, 1);

    // Reset in INTR3 discards a pending NMI edge
    steps(4, 2'd0);
    IRQ = 1'b1;
    step(2'd1);
    IRQ = 1'b0;
    steps(3, 2'd0);
    chk("intr3", PHASE, 27);
    NMI = 1'b1;
    tick(1'b0);
    do_reset();
    chk("rst_mid_phase", PHASE, 0);
    chk("rst_mid_opcode", OPCODE, 8'h01);
    steps(5, 2'd0);
    step(2'd1);
    chk("nmi_discarded", PHASE, 4);
    NMI = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (m_phase == 62 || $urandom_range(0, 99) == 0) do_reset();
      DIN = 8'($urandom);
      r = $urandom_range(0, 99);
      mc_next = (r < 55) ? 2'd0 : (r < 85) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
      IRQ = ($urandom_range(0, 9) < 2);
      IMASK = 1'($urandom_range(0, 1));
      tick(1'b1);
      n = $urandom_range(2, 4);
      for (int k = 0; k < n; k++) begin
        NMI = ($urandom_range(0, 19) == 0);
        tick(1'b0);
      end
      NMI = 1'b0;
    end

    tick(1'b0);
    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d queued, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
